add_round_key_stream: RTL and testbench

//  Streaming, parametrised AddRoundKey stage: XORs each input state block with a round key

---
 rtl/add_round_key_stream.sv | 181 ++++++++++++++++++
 tb/tb_add_round_key_stream.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_stream.sv
// add_round_key_stream: streaming AddRoundKey stage.
// Each accepted state block is XORed with a round key read from an internal
// key file (written by the key-expansion block through its own port). Results
// go into a 2-entry output buffer built from a head and a tail register, so
// the output is always registered and never has a combinational path from in_*.
// Optional feature: define ARK_PARITY_EN to add out_parity, the per-byte even
// parity of out_data, computed at push and stored with each buffer entry.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload until the transfer. in_ready
// depends only on the registered buffer count (and reset), never on out_ready.
module add_round_key_stream #(
  parameter int DATA_W    = 128,
  parameter int KEY_DEPTH = 15,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_round,
  output logic              err_idx
`ifdef ARK_PARITY_EN
  ,
  output logic [DATA_W/8-1:0] out_parity
`endif
);

  // The file spans the whole index space so any index is a legal array
  // reference; entries at or above KEY_DEPTH are never written and never read.
  localparam int unsigned FILE_N = 2 ** IDX_W;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(KEY_DEPTH);

  logic [DATA_W-1:0] key_q [FILE_N];

  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic [IDX_W-1:0]  head_round_q, head_round_d;
  logic [IDX_W-1:0]  tail_round_q, tail_round_d;
  logic              err_q, err_d;

  logic              push;
  logic              pop;
  logic              rd_ok;
  logic              wr_ok;
  logic [DATA_W-1:0] blk_data;

  assign rd_ok = ({1'b0, in_round} < DEPTH_C);
  assign wr_ok = ({1'b0, key_wr_idx} < DEPTH_C);

  assign in_ready  = rst && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Out-of-range rounds use an all-zero key; the key file read sees the
  // contents before this edge, so a same-cycle write to that entry is not seen.
  assign blk_data = in_data ^ (rd_ok ? key_q[in_round] : '0);

  assign out_data  = head_data_q;
  assign out_round = head_round_q;
  assign err_idx   = err_q;

`ifdef ARK_PARITY_EN
  localparam int NB = DATA_W / 8;

  logic [NB-1:0] blk_par;
  logic [NB-1:0] head_par_q, head_par_d;
  logic [NB-1:0] tail_par_q, tail_par_d;

  // Even parity of each byte of the block being pushed.
  always_comb begin
    blk_par = '0;
    for (int i = 0; i < NB; i++) begin
      blk_par[i] = ^blk_data[8*i +: 8];
    end
  end

  assign out_parity = head_par_q;
`endif

  // Key file: cleared by reset, out-of-range write addresses are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FILE_N; i++) begin
        key_q[i] <= '0;
      end
    end else if (key_wr_en && wr_ok) begin
      key_q[key_wr_idx] <= key_wr_data;
    end
  end

  // Buffer next state: head is the visible entry, tail the one queued behind.
  // A pop that empties the buffer leaves head untouched so out_data holds.
  always_comb begin
    count_d      = count_q;
    head_data_d  = head_data_q;
    head_round_d = head_round_q;
    tail_data_d  = tail_data_q;
    tail_round_d = tail_round_q;
`ifdef ARK_PARITY_EN
    head_par_d   = head_par_q;
    tail_par_d   = tail_par_q;
`endif
    err_d        = err_q | (push & ~rd_ok);
    unique case ({push, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_data_d  = blk_data;
          head_round_d = in_round;
`ifdef ARK_PARITY_EN
          head_par_d   = blk_par;
`endif
        end else begin
          tail_data_d  = blk_data;
          tail_round_d = in_round;
`ifdef ARK_PARITY_EN
          tail_par_d   = blk_par;
`endif
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) begin
          head_data_d  = tail_data_q;
          head_round_d = tail_round_q;
`ifdef ARK_PARITY_EN
          head_par_d   = tail_par_q;
`endif
        end
      end
      2'b11: begin
        // Only reachable with count 1: the new block replaces the departing head.
        head_data_d  = blk_data;
        head_round_d = in_round;
`ifdef ARK_PARITY_EN
        head_par_d   = blk_par;
`endif
      end
      default: ;
    endcase
  end

  // Buffer and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= 2'd0;
      head_data_q  <= '0;
      head_round_q <= '0;
      tail_data_q  <= '0;
      tail_round_q <= '0;
      err_q        <= 1'b0;
`ifdef ARK_PARITY_EN
      head_par_q   <= '0;
      tail_par_q   <= '0;
`endif
    end else begin
      count_q      <= count_d;
      head_data_q  <= head_data_d;
      head_round_q <= head_round_d;
      tail_data_q  <= tail_data_d;
      tail_round_q <= tail_round_d;
      err_q        <= err_d;
`ifdef ARK_PARITY_EN
      head_par_q   <= head_par_d;
      tail_par_q   <= tail_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_add_round_key_stream.sv
// tb_add_round_key_stream: randomized bench for add_round_key_stream with a
// queue-based reference model (key array + FIFO of expected {round, data}).
module tb_add_round_key_stream;
  localparam int DATA_W    = 128;
  localparam int KEY_DEPTH = 15;
  localparam int IDX_W     = 4;
  localparam int NB        = DATA_W / 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              key_wr_en;
  logic [IDX_W-1:0]  key_wr_idx;
  logic [DATA_W-1:0] key_wr_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_round;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_round;
  logic              err_idx;
`ifdef ARK_PARITY_EN
  logic [NB-1:0]     out_parity;
`endif

  add_round_key_stream #(.DATA_W(DATA_W), .KEY_DEPTH(KEY_DEPTH), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_round    (in_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_round   (out_round),
    .err_idx     (err_idx)
`ifdef ARK_PARITY_EN
    ,
    .out_parity  (out_parity)
`endif
  );

  // reference model state
  logic [DATA_W-1:0]       mkey [16];
  logic [IDX_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]       last_data;
  logic [IDX_W-1:0]        last_round;
  logic                    merr;
  int                      n_tests = 0;
  int                      n_fail  = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mkey[i] = '0;
    exp_q.delete();
    last_data  = '0;
    last_round = '0;
    merr       = 1'b0;
  endtask

  // driver
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] r,
                       input logic ordy, input logic wen, input logic [IDX_W-1:0] widx,
                       input logic [DATA_W-1:0] wdata);
    in_valid    = v;
    in_data     = d;
    in_round    = r;
    out_ready   = ordy;
    key_wr_en   = wen;
    key_wr_idx  = widx;
    key_wr_data = wdata;
  endtask

  // One clock: check outputs at the negedge, advance the model, cross the edge.
  task automatic cycle(output bit acc);
    logic [IDX_W+DATA_W-1:0] head;
    logic [DATA_W-1:0]       kd;
    bit                      pop;
    @(negedge clk);
    check("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
    check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("out_data", out_data, head[DATA_W-1:0]);
      check("out_round", 128'(out_round), 128'(head[DATA_W +: IDX_W]));
`ifdef ARK_PARITY_EN
      check("out_parity", 128'(out_parity), 128'(byte_parity(head[DATA_W-1:0])));
`endif
    end else begin
      check("out_data_hold", out_data, last_data);
      check("out_round_hold", 128'(out_round), 128'(last_round));
    end
    acc = in_valid && (exp_q.size() < 2);
    pop = out_ready && (exp_q.size() != 0);
    if (pop) begin
      head       = exp_q.pop_front();
      last_data  = head[DATA_W-1:0];
      last_round = head[DATA_W +: IDX_W];
    end
    if (acc) begin
      kd = (int'(in_round) < KEY_DEPTH) ? mkey[in_round] : '0;
      exp_q.push_back({in_round, in_data ^ kd});
      if (int'(in_round) >= KEY_DEPTH) merr = 1'b1;
    end
    if (key_wr_en && int'(key_wr_idx) < KEY_DEPTH) mkey[key_wr_idx] = key_wr_data;
    @(posedge clk);
    #1;
    check("err_idx", 128'(err_idx), 128'(merr));
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bit                acc;
    int                k;
    int                j;
    logic [DATA_W-1:0] blk [3];

    // 1: reset held with random inputs
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), rnd128(), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 15)), rnd128());
      @(negedge clk);
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_data", out_data, '0);
      check("rst_err_idx", 128'(err_idx), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(0));
`ifdef ARK_PARITY_EN
      check("rst_out_parity", 128'(out_parity), 128'(0));
`endif
    end
    @(posedge clk);
    #3;
    drive(0, '0, '0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;

    // 2: basic XOR
    drive(0, '0, '0, 1'b1, 1'b1, 4'd0, {16{8'h0f}});
    cycle(acc);
    drive(1, {16{8'hf0}}, 4'd0, 1'b1, 1'b0, '0, '0);
    cycle(acc);
    check("basic_out_valid", 128'(out_valid), 128'(1));
    check("basic_out_data", out_data, {16{8'hff}});
    check("basic_out_round", 128'(out_round), 128'(0));
    drive(0, '0, '0, 1'b1, 1'b0, '0, '0);
    cycle(acc);

    // 3: backpressure
    for (int i = 1; i <= 3; i++) begin
      drive(0, '0, '0, 1'b1, 1'b1, 4'(i), rnd128());
      cycle(acc);
    end
    for (int i = 0; i < 3; i++) blk[i] = rnd128();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, blk[k], 4'(k + 1), 1'b0, 1'b0, '0, '0);
      cycle(acc);
      if (acc) k++;
    end
    check("bp_accepted", 128'(k), 128'(2));
    j = -1;
    for (int i = 0; i < 10 && k < 3; i++) begin
      drive(1, blk[k], 4'(k + 1), 1'b1, 1'b0, '0, '0);
      cycle(acc);
      if (acc) begin
        k++;
        j = i;
      end
    end
    check("bp_third_cycle", 128'(j), 128'(1));
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      drive(0, '0, '0, 1'b1, 1'b0, '0, '0);
      cycle(acc);
    end
    check("bp_drained", 128'(exp_q.size()), 128'(0));

    // 4: write/read collision
    drive(0, '0, '0, 1'b1, 1'b1, 4'd5, {16{8'haa}});
    cycle(acc);
    drive(1, '0, 4'd5, 1'b1, 1'b1, 4'd5, {16{8'h55}});
    cycle(acc);
    check("collision_old_key", out_data, {16{8'haa}});
    drive(1, '0, 4'd5, 1'b1, 1'b0, '0, '0);
    cycle(acc);
    check("collision_new_key", out_data, {16{8'h55}});
    drive(0, '0, '0, 1'b1, 1'b0, '0, '0);
    cycle(acc);

    // 5: bad index, sticky error
    drive(1, 128'h123456789abcdef0123456789abcdef0, 4'd15, 1'b1, 1'b0, '0, '0);
    cycle(acc);
    check("bad_idx_data", out_data, 128'h123456789abcdef0123456789abcdef0);
    check("bad_idx_round", 128'(out_round), 128'(15));
    for (int i = 0; i < 4; i++) begin
      drive(1, rnd128(), 4'($urandom_range(0, 14)), 1'b1, 1'b0, '0, '0);
      cycle(acc);
    end
    check("bad_idx_sticky", 128'(err_idx), 128'(1));
    drive(0, '0, '0, 1'b1, 1'b0, '0, '0);
    cycle(acc);

    // 6: mid-stream reset
    for (int i = 0; i < 2; i++) begin
      drive(1, rnd128(), 4'd0, 1'b0, 1'b0, '0, '0);
      cycle(acc);
    end
    check("mid_buffered", 128'(exp_q.size()), 128'(2));
    #2;
    rst = 1'b0;
    #1;
    check("mid_out_valid", 128'(out_valid), 128'(0));
    check("mid_out_data", out_data, '0);
    check("mid_in_ready", 128'(in_ready), 128'(0));
    check("mid_err_idx", 128'(err_idx), 128'(0));
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    blk[0] = rnd128();
    drive(1, blk[0], 4'd0, 1'b1, 1'b0, '0, '0);
    cycle(acc);
    check("mid_zero_key", out_data, blk[0]);
    drive(0, '0, '0, 1'b1, 1'b0, '0, '0);
    cycle(acc);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd128(), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)), rnd128());
      cycle(acc);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      drive(0, '0, '0, 1'b1, 1'b0, '0, '0);
      cycle(acc);
    end
    check("final_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
